// File: rtl/found_reporter_if.sv
// Bundle of the hit-detection inputs and UART/status outputs of found_reporter.
// No latency of its own; pure wiring between search logic, reporter and host pin.
// No backpressure: found/counter_in are free-running, outputs are status levels.
interface found_reporter_if;
  logic [7:0]  found;
  logic [28:0] counter_in;
  logic        tx;
  logic        busy;
  logic        captured;
  logic        multi_hit;

  // Driver side (search pipelines / testbench)
  modport master (
    output found,
    output counter_in,
    input  tx,
    input  busy,
    input  captured,
    input  multi_hit
  );

  // Reporter side
  modport slave (
    input  found,
    input  counter_in,
    output tx,
    output busy,
    output captured,
    output multi_hit
  );
endinterface

// File: rtl/found_reporter.sv
// Latches the first MD5 hit, rebuilds the 32-bit candidate and sends "F<8 hex>\r\n" over UART 8N1.
// Latency: hit at cycle t -> LOAD at t+1 -> start bit at t+2; frame is 110*CLKS_PER_BIT cycles.
// No backpressure: found is sampled once, later hits are dropped; optional repeat via FOUND_REPORTER_REPEAT_EN.
module found_reporter #(
  parameter int CLKS_PER_BIT = 868,
  parameter int PIPE_LATENCY = 64,
  parameter int REPEAT_GAP   = 100_000_000
) (
  input  logic              CLK,
  input  logic              reset,
  found_reporter_if.slave   bus
);

  // Elaboration-time parameter sanity: STOP is shortened by one cycle to make
  // room for NEXT, so a bit must last at least two clocks.
  if (CLKS_PER_BIT < 2 || REPEAT_GAP < 1) begin : g_bad_param
    $error("found_reporter: CLKS_PER_BIT must be >= 2 and REPEAT_GAP >= 1");
  end

  localparam int BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST      = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_STOP_LAST = BW'(CLKS_PER_BIT - 2);
  localparam logic [28:0]   LAT29          = 29'(PIPE_LATENCY);
  localparam logic [3:0]    LAST_CHAR      = 4'd10;

  localparam logic [3:0] S_IDLE  = 4'd0;
  localparam logic [3:0] S_LOAD  = 4'd1;
  localparam logic [3:0] S_START = 4'd2;
  localparam logic [3:0] S_DATA  = 4'd3;
  localparam logic [3:0] S_STOP  = 4'd4;
  localparam logic [3:0] S_NEXT  = 4'd5;
  localparam logic [3:0] S_DONE  = 4'd6;
  localparam logic [3:0] S_GAP   = 4'd7;

`ifdef FOUND_REPORTER_REPEAT_EN
  localparam int GW = (REPEAT_GAP > 1) ? $clog2(REPEAT_GAP) : 1;
  localparam logic [GW-1:0] GAP_LAST = GW'(REPEAT_GAP - 1);
`endif

  logic [3:0]    state_q, state_d;
  logic [31:0]   cand_q, cand_d;
  logic          captured_q, captured_d;
  logic          multi_q, multi_d;
  logic          busy_q, busy_d;
  logic          tx_q, tx_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [3:0]    char_q, char_d;
  logic [7:0]    shift_q, shift_d;
`ifdef FOUND_REPORTER_REPEAT_EN
  logic [GW-1:0] gap_q, gap_d;
`endif

  logic [2:0]    hit_idx;
  logic          hit_multi;
  logic [28:0]   hit_base;

  // One ASCII hex digit, uppercase.
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  // Character idx of the frame 'F', 8 hex digits MSN first, CR, LF.
  function automatic logic [7:0] frame_char(input logic [3:0] idx, input logic [31:0] c);
    logic [31:0] sh;
    sh = c >> {(4'd8 - idx), 2'b00};
    if (idx == 4'd0)      return 8'h46;
    else if (idx <= 4'd8) return hex_ascii(sh[3:0]);
    else if (idx == 4'd9) return 8'h0D;
    else                  return 8'h0A;
  endfunction

  // Lowest set found bit wins; popcount flags simultaneous hits; counter is rewound by pipe depth.
  always_comb begin
    hit_idx = 3'd0;
    for (int i = 7; i >= 0; i--) begin
      if (bus.found[i]) hit_idx = 3'(i);
    end
    hit_multi = ($countones(bus.found) > 1);
    hit_base  = bus.counter_in - LAT29;
  end

  // Frame FSM: capture, then start/data/stop per character, NEXT picks the following one.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    captured_d = captured_q;
    multi_d    = multi_q;
    busy_d     = busy_q;
    tx_d       = tx_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    char_d     = char_q;
    shift_d    = shift_q;
`ifdef FOUND_REPORTER_REPEAT_EN
    gap_d      = gap_q;
`endif

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (bus.found != 8'h00 && !captured_q) begin
          cand_d     = {hit_base, hit_idx};
          multi_d    = hit_multi;
          captured_d = 1'b1;
          busy_d     = 1'b1;
          state_d    = S_LOAD;
        end
      end

      S_LOAD: begin
        char_d  = 4'd0;
        shift_d = frame_char(4'd0, cand_q);
        baud_d  = '0;
        tx_d    = 1'b0;
        state_d = S_START;
      end

      S_START: begin
        if (baud_q == BAUD_LAST) begin
          baud_d  = '0;
          bit_d   = 3'd0;
          tx_d    = shift_q[0];
          shift_d = {1'b0, shift_q[7:1]};
          state_d = S_DATA;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_DATA: begin
        if (baud_q == BAUD_LAST) begin
          baud_d = '0;
          if (bit_q == 3'd7) begin
            tx_d    = 1'b1;
            state_d = S_STOP;
          end else begin
            bit_d   = bit_q + 3'd1;
            tx_d    = shift_q[0];
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      // Last stop-bit clock is spent in NEXT so characters stay back to back.
      S_STOP: begin
        if (baud_q == BAUD_STOP_LAST) begin
          baud_d  = '0;
          state_d = S_NEXT;
        end else begin
          baud_d = baud_q + 1'b1;
        end
      end

      S_NEXT: begin
        if (char_q == LAST_CHAR) begin
`ifdef FOUND_REPORTER_REPEAT_EN
          gap_d   = '0;
          tx_d    = 1'b1;
          state_d = S_GAP;
`else
          busy_d  = 1'b0;
          tx_d    = 1'b1;
          state_d = S_DONE;
`endif
        end else begin
          char_d  = char_q + 4'd1;
          shift_d = frame_char(char_q + 4'd1, cand_q);
          tx_d    = 1'b0;
          state_d = S_START;
        end
      end

`ifdef FOUND_REPORTER_REPEAT_EN
      S_GAP: begin
        tx_d = 1'b1;
        if (gap_q == GAP_LAST) begin
          char_d  = 4'd0;
          shift_d = frame_char(4'd0, cand_q);
          baud_d  = '0;
          tx_d    = 1'b0;
          state_d = S_START;
        end else begin
          gap_d = gap_q + 1'b1;
        end
      end
`endif

      S_DONE: begin
        tx_d   = 1'b1;
        busy_d = 1'b0;
      end

      default: begin
        tx_d    = 1'b1;
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers; reset abandons any frame in flight and re-arms capture.
  always_ff @(posedge CLK) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cand_q     <= '0;
      captured_q <= 1'b0;
      multi_q    <= 1'b0;
      busy_q     <= 1'b0;
      tx_q       <= 1'b1;
      baud_q     <= '0;
      bit_q      <= 3'd0;
      char_q     <= 4'd0;
      shift_q    <= 8'h00;
`ifdef FOUND_REPORTER_REPEAT_EN
      gap_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      cand_q     <= cand_d;
      captured_q <= captured_d;
      multi_q    <= multi_d;
      busy_q     <= busy_d;
      tx_q       <= tx_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      char_q     <= char_d;
      shift_q    <= shift_d;
`ifdef FOUND_REPORTER_REPEAT_EN
      gap_q      <= gap_d;
`endif
    end
  end

  assign bus.tx        = tx_q;
  assign bus.busy      = busy_q;
  assign bus.captured  = captured_q;
  assign bus.multi_hit = multi_q;

endmodule

// File: doc/found_reporter.md
# found_reporter

Result reporter for the MD5 brute-force top level. It watches the eight per-pipeline `found` flags and the shared 29-bit candidate counter, and reconstructs the 32-bit candidate that produced the hit. It then transmits that candidate to the host over a UART TX line as an ASCII frame. It is the host-facing transmit end of the search: the driver produces hits, and this block serialises them out on the existing `found_pin` path.

## Interface
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200). Must be ≥ 2.
- `PIPE_LATENCY`, default 64: counter increments between a candidate entering the pipelines and its `found` asserting.
- `REPEAT_GAP`, default 100_000_000: idle cycles between repeated frames. Used only with `FOUND_REPORTER_REPEAT_EN`.
- `CLK`  in  1  system clock; everything is on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `found`  in  8  per-pipeline hit flags; bit i corresponds to low candidate bits 3'di.
- `counter_in`  in  29  current shared candidate counter (upper 29 bits of the candidate).
- `tx`  out  1  UART serial output, 8N1, LSB first; idles high.
- `busy`  out  1  high while a frame is in flight or a result is latched and pending.
- `captured`  out  1  high once a result has been latched; held until reset.
- `multi_hit`  out  1  high if more than one `found` bit was set in the capture cycle.

## Operation
- Reset values: `tx`=1, `busy`=0, `captured`=0, `multi_hit`=0. The FSM enters IDLE, the candidate register clears and the baud counter clears.
- FSM states: IDLE → LOAD → START → DATA → STOP → NEXT, then back to START or to DONE. The repeat build adds a GAP state.
- IDLE, capture rule: on the first cycle with `found != 0` and `captured == 0`, the block latches:
  - `idx` = index of the lowest set bit (lowest index wins);
  - `base` = (`counter_in` − `PIPE_LATENCY`) mod 2^29;
  - `cand` = {`base`, `idx`};
  - `multi_hit` = (popcount(`found`) > 1).
  - It then sets `captured` and moves to LOAD.
- After capture, `found` is ignored until reset, including new or different bits.
- Frame format: 11 characters, sent in this order:
  - 'F' (0x46);
  - 8 uppercase hex digits of `cand`, most significant nibble first ('0'–'9' = 0x30–0x39, 'A'–'F' = 0x41–0x46);
  - CR (0x0D), then LF (0x0A).
- Character framing:
  - START holds `tx`=0 for `CLKS_PER_BIT` cycles.
  - DATA shifts out 8 bits LSB first, `CLKS_PER_BIT` cycles each.
  - STOP holds `tx`=1 for `CLKS_PER_BIT` cycles.
  - NEXT selects the next character. It goes to DONE after LF.
- DONE: `tx`=1 and `busy`=0. The block stays here until reset.
- Reset mid-frame: `tx` returns high on the next edge and the partial frame is abandoned; no completion is required. The next hit is captured normally.
- `reset` together with `found` in the same cycle: reset wins and nothing is captured.

## Timing
- Hit in cycle t (the first `found != 0`): state, `cand` and `captured` are registered at edge t+1. `busy`=1 from t+1.
- LOAD lasts one cycle. The start bit of 'F' drives `tx`=0 from edge t+2.
- Each character takes exactly 10·`CLKS_PER_BIT` cycles. Characters are back to back, with no idle gap between stop bit and next start bit.
- Full frame: 110·`CLKS_PER_BIT` cycles. `busy` falls on the edge that ends the LF stop bit.
- Counter subtraction wraps modulo 2^29. Example: `counter_in`=5 with `PIPE_LATENCY`=64 gives `base`=0x1FFF_FFC5.
- `tx` is registered directly from FSM and shift state, with no combinational path from `found`.

## Configuration
- `FOUND_REPORTER_REPEAT_EN` defined:
  - After LF, the FSM enters GAP with `tx`=1 for `REPEAT_GAP` cycles, then resends the identical frame (same `cand`) indefinitely until reset.
  - `busy` stays 1 throughout.
- Undefined: exactly one frame per capture, then DONE. GAP and its counter are not built, and `REPEAT_GAP` is unused.

## Test plan
- Single hit, `CLKS_PER_BIT`=4, `PIPE_LATENCY`=64:
  - Stimulus: `counter_in`=0x0000_1040, `found`=8'b0000_0100 for one cycle.
  - Required: `cand`=0x0000_8002, decoded UART bytes "F00008002\r\n", `tx` low at t+2, `busy` low 440 cycles after t+2, `multi_hit`=0.
- Simultaneous hits:
  - Stimulus: `found`=8'b1001_0000, `counter_in`=0x100.
  - Required: idx=4, `cand`=0x0000_0604 (base 0xC0), `multi_hit`=1.
- Wrap-around:
  - Stimulus: `counter_in`=5, `found`=8'h01.
  - Required: frame "FFFFFFE28\r\n".
- Post-capture lockout:
  - Stimulus: a second `found`=8'h80 with a different `counter_in` during and after the frame.
  - Required: frame content unchanged, and no second frame without repeat.
- Reset mid-frame:
  - Stimulus: assert `reset` during the DATA bits of the third character.
  - Required: `tx`=1, `busy`=0 and `captured`=0 on the next edge. A new hit then produces a complete, correct frame.
- Repeat build:
  - Stimulus: `FOUND_REPORTER_REPEAT_EN` defined, `REPEAT_GAP`=20, one hit.
  - Required: identical frames separated by exactly 20 idle-high cycles, at least 3 frames observed.
